// File: rtl/bot_motion.sv
// Bot motion unit: commands edit a shadow pose, which is copied to the
// visible LocX/LocY/BotInfo registers on the next vertical-blank tick.
module bot_motion (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_x,
    input  logic [7:0] cmd_y,
    input  logic       frame_tick,
    output logic [7:0] LocX_reg,
    output logic [7:0] LocY_reg,
    output logic [7:0] BotInfo_reg,
    output logic       upd_tick
);

    typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

    localparam logic [2:0] OP_FWD = 3'd1;
    localparam logic [2:0] OP_REV = 3'd2;
    localparam logic [2:0] OP_ROTL = 3'd3;
    localparam logic [2:0] OP_ROTR = 3'd4;
    localparam logic [2:0] OP_SETP = 3'd5;
    localparam logic [6:0] HOME = 7'd62;

    state_t     state_q, state_d;
    logic       ready_q, ready_d;
    logic [2:0] op_q, op_d;
    logic [6:0] x_q, x_d, y_q, y_d;
    logic [6:0] sx_q, sx_d, sy_q, sy_d;
    logic [2:0] so_q, so_d;
    logic       smv_q, smv_d;
    logic [6:0] locx_q, locx_d, locy_q, locy_d;
    logic [3:0] info_q, info_d;
    logic       upd_q, upd_d;
    logic [6:0] dx, dy;
    logic       unused_bits;

    assign unused_bits = ^{cmd_x[7], cmd_y[7]};

    // -1 is 7'h7F so add/sub wrap modulo 128 naturally
    always_comb begin
        dx = 7'd0;
        dy = 7'd0;
        unique case (so_q)
            3'd0: dy = 7'h7F;
            3'd1: begin dx = 7'd1;  dy = 7'h7F; end
            3'd2: dx = 7'd1;
            3'd3: begin dx = 7'd1;  dy = 7'd1;  end
            3'd4: dy = 7'd1;
            3'd5: begin dx = 7'h7F; dy = 7'd1;  end
            3'd6: dx = 7'h7F;
            3'd7: begin dx = 7'h7F; dy = 7'h7F; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        so_d    = so_q;
        smv_d   = smv_q;
        locx_d  = locx_q;
        locy_d  = locy_q;
        info_d  = info_q;
        upd_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    op_d    = cmd_op;
                    x_d     = cmd_x[6:0];
                    y_d     = cmd_y[6:0];
                    state_d = EXEC;
                end
            end
            EXEC: begin
                smv_d = 1'b0;
                unique case (op_q)
                    OP_FWD: begin
                        sx_d  = sx_q + dx;
                        sy_d  = sy_q + dy;
                        smv_d = 1'b1;
                    end
                    OP_REV: begin
                        sx_d  = sx_q - dx;
                        sy_d  = sy_q - dy;
                        smv_d = 1'b1;
                    end
                    OP_ROTL: so_d = so_q - 3'd1;
                    OP_ROTR: so_d = so_q + 3'd1;
                    OP_SETP: begin
                        sx_d = x_q;
                        sy_d = y_q;
                    end
                    default: ;
                endcase
                state_d = HOLD;
            end
            HOLD: begin
                if (frame_tick) begin
                    locx_d  = sx_q;
                    locy_d  = sy_q;
                    info_d  = {smv_q, so_q};
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            op_q    <= 3'd0;
            x_q     <= 7'd0;
            y_q     <= 7'd0;
            sx_q    <= HOME;
            sy_q    <= HOME;
            so_q    <= 3'd0;
            smv_q   <= 1'b0;
            locx_q  <= HOME;
            locy_q  <= HOME;
            info_q  <= 4'd0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            so_q    <= so_d;
            smv_q   <= smv_d;
            locx_q  <= locx_d;
            locy_q  <= locy_d;
            info_q  <= info_d;
            upd_q   <= upd_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign LocX_reg    = {1'b0, locx_q};
    assign LocY_reg    = {1'b0, locy_q};
    assign BotInfo_reg = {4'b0000, info_q};
    assign upd_tick    = upd_q;

endmodule

// File: tb/tb_bot_motion.sv
// Scoreboard bench for bot_motion: stimulus pushes expected commits,
// a monitor pops and compares on every upd_tick pulse.
module tb_bot_motion;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_x = 8'd0;
    logic [7:0] cmd_y = 8'd0;
    logic       frame_tick = 1'b0;
    logic [7:0] LocX_reg, LocY_reg, BotInfo_reg;
    logic       upd_tick;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    bot_motion dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .frame_tick(frame_tick),
        .LocX_reg(LocX_reg), .LocY_reg(LocY_reg),
        .BotInfo_reg(BotInfo_reg), .upd_tick(upd_tick)
    );

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: every upd_tick must match the oldest outstanding commit
    always @(negedge clk) begin
        if (upd_tick === 1'b1) begin
            logic [23:0] got, want;
            got = {LocX_reg, LocY_reg, BotInfo_reg};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_upd got=%h want=none", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL commit got=%h want=%h", got, want);
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y);
        int n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout got=%b want=1", cmd_ready);
        end
        cmd_op = op;
        cmd_x = x;
        cmd_y = y;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic commit(input logic [7:0] ex, input logic [7:0] ey,
                          input logic [7:0] ei);
        @(negedge clk);
        exp_q.push_back({ex, ey, ei});
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input logic [2:0] op, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] ex,
                        input logic [7:0] ey, input logic [7:0] ei);
        send(op, x, y);
        commit(ex, ey, ei);
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_locx", LocX_reg, 8'd62);
        chk("rst_locy", LocY_reg, 8'd62);
        chk("rst_info", BotInfo_reg, 8'h00);
        chk("rst_upd", {7'd0, upd_tick}, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {7'd0, cmd_ready}, 8'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // FWD heading N from home
        step(3'd1, 8'd0, 8'd0, 8'd62, 8'd61, 8'h08);

        // ROT_L then a held FWD that must wait for the commit
        do_reset();
        send(3'd3, 8'd0, 8'd0);
        cmd_op = 3'd1;
        cmd_valid = 1'b1;
        chk("busy_exec", {7'd0, cmd_ready}, 8'd0);
        @(negedge clk);
        chk("busy_hold", {7'd0, cmd_ready}, 8'd0);
        exp_q.push_back({8'd62, 8'd62, 8'h07});
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        commit(8'd61, 8'd61, 8'h0F);

        // Wrap on X at the east edge
        do_reset();
        step(3'd5, 8'd127, 8'd0, 8'd127, 8'd0, 8'h00);
        step(3'd4, 8'd0, 8'd0, 8'd127, 8'd0, 8'h01);
        step(3'd4, 8'd0, 8'd0, 8'd127, 8'd0, 8'h02);
        step(3'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'h0A);

        // Rotate left through 0 to NW, then diagonal wraps
        step(3'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'h01);
        step(3'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'h00);
        step(3'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'h07);
        step(3'd1, 8'd0, 8'd0, 8'd127, 8'd127, 8'h0F);
        step(3'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'h07);
        step(3'd2, 8'd0, 8'd0, 8'd1, 8'd1, 8'h0F);

        // SET_POS drops bit 7; NOP and illegal clear moved only
        step(3'd5, 8'hFF, 8'h85, 8'd127, 8'd5, 8'h07);
        step(3'd1, 8'd0, 8'd0, 8'd126, 8'd4, 8'h0F);
        step(3'd0, 8'd9, 8'd9, 8'd126, 8'd4, 8'h07);
        step(3'd1, 8'd0, 8'd0, 8'd125, 8'd3, 8'h0F);
        step(3'd6, 8'd9, 8'd9, 8'd125, 8'd3, 8'h07);

        // Accept coincident with frame_tick: that tick is ignored
        @(negedge clk);
        cmd_op = 3'd1;
        cmd_valid = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        frame_tick = 1'b0;
        chk("coinc_upd", {7'd0, upd_tick}, 8'd0);
        chk("coinc_locx", LocX_reg, 8'd125);
        commit(8'd124, 8'd2, 8'h0F);

        // Reset during HOLD discards the pending FWD
        send(3'd1, 8'd0, 8'd0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("hold_rst_locx", LocX_reg, 8'd62);
        chk("hold_rst_locy", LocY_reg, 8'd62);
        chk("hold_rst_info", BotInfo_reg, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            @(negedge clk);
            frame_tick = 1'b0;
            chk("idle_tick_upd", {7'd0, upd_tick}, 8'd0);
            chk("idle_tick_locy", LocY_reg, 8'd62);
        end
        step(3'd0, 8'd0, 8'd0, 8'd62, 8'd62, 8'h00);

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_commits got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
